// File: rtl/axi_ic_defines_pkg.sv
// ---------------------------------------------------------------------------
// axi_ic_defines
//   Shared interconnect definitions used by the AXI read/write return-path
//   routers and their helper blocks.
//   - AXI RRESP/BRESP encodings
//   - master-index width derivation (macro and equivalent constant function)
// ---------------------------------------------------------------------------
`ifndef AXI_IC_DEFINES_SVH
`define AXI_IC_DEFINES_SVH
// Width of a master index for n masters; a single master still needs 1 bit.
`define AXI_IC_IDX_W(n) (((n) > 1) ? $clog2(n) : 1)
`endif

package axi_ic_defines;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // Constant-function form of AXI_IC_IDX_W, usable in parameter port lists
  // without depending on macro visibility across compilation units.
  function automatic int idx_width(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/axi_ic_order_fifo.sv
// ---------------------------------------------------------------------------
// axi_ic_order_fifo
//   Register-based synchronous FIFO that records the order in which bursts
//   were granted, so responses can be steered back in the same order.
//   Shared by the R- and B-channel return routers.
//
//   Ports
//     clk, rst      clock, asynchronous active-high reset
//     push          request to write push_data
//     push_data     entry to append (master index)
//     pop           request to retire the head entry
//     head          combinational view of the oldest entry
//     count         number of stored entries (registered)
//     full, empty   registered status flags
//     push_ok       push was taken this cycle (a same-cycle pop frees room)
// ---------------------------------------------------------------------------
module axi_ic_order_fifo #(
  parameter  int WIDTH = 2,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             push_ok
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             full_r;
  logic             empty_r;

  logic             pop_ok_s;
  logic             push_ok_s;
  logic [CNT_W-1:0] count_nxt_s;

  // Qualify push/pop and compute the next occupancy.
  always_comb begin
    pop_ok_s    = pop & ~empty_r;
    // A pop in the same cycle frees the slot, so a push is legal even when full.
    push_ok_s   = push & (~full_r | pop_ok_s);
    count_nxt_s = count_r;
    if (push_ok_s && !pop_ok_s) begin
      count_nxt_s = count_r + CNT_W'(1);
    end else if (!push_ok_s && pop_ok_s) begin
      count_nxt_s = count_r - CNT_W'(1);
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Pointer, occupancy and status-flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      // DEPTH is a power of two, so pointers wrap naturally.
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == CNT_W'(DEPTH));
      empty_r <= (count_nxt_s == {CNT_W{1'b0}});
    end
  end

  // Entry storage; when full with a simultaneous pop the write lands in the
  // slot being read, which is safe because the read is this cycle's value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  assign head    = mem_r[rd_ptr_r];
  assign count   = count_r;
  assign full    = full_r;
  assign empty   = empty_r;
  assign push_ok = push_ok_s;

endmodule

// File: rtl/axi_rd_resp_router.sv
// ---------------------------------------------------------------------------
// axi_rd_resp_router
//   Return path of the round-robin read arbiter for a single in-order slave.
//   Every accepted AR records its winning master index in an order FIFO; the
//   shared slave R channel is then steered, one whole burst per entry, to that
//   master through a one-beat registered output slice. The entry retires on
//   the beat carrying RLAST.
//
//   Ports
//     clk, rst       clock, asynchronous active-high reset
//     ar_fire        AR handshake completed on the slave side
//     ar_index       master index granted for that AR
//     order_full     order FIFO full; arbiter must not grant
//     outstanding    bursts in flight (FIFO occupancy)
//     push_err       sticky: AR dropped (FIFO full without pop, or bad index)
//     s_r*           shared slave R channel (s_rready driven here)
//     m_r*           per-master R channels, lane i at [i*W +: W]
// ---------------------------------------------------------------------------
module axi_rd_resp_router
  import axi_ic_defines::*;
#(
  parameter  int REQ_NUM    = 3,
  parameter  int DATA_WIDTH = 128,
  parameter  int DEPTH      = 4,
  localparam int IDX_W      = idx_width(REQ_NUM),
  localparam int CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ar_fire,
  input  logic [IDX_W-1:0]              ar_index,
  output logic                          order_full,
  output logic [CNT_W-1:0]              outstanding,
  output logic                          push_err,
  input  logic [DATA_WIDTH-1:0]         s_rdata,
  input  logic [1:0]                    s_rresp,
  input  logic                          s_rlast,
  input  logic                          s_rvalid,
  output logic                          s_rready,
  output logic [REQ_NUM*DATA_WIDTH-1:0] m_rdata,
  output logic [REQ_NUM*2-1:0]          m_rresp,
  output logic [REQ_NUM-1:0]            m_rlast,
  output logic [REQ_NUM-1:0]            m_rvalid,
  input  logic [REQ_NUM-1:0]            m_rready
);

  // Order FIFO interface
  logic             idx_ok_s;
  logic             fifo_push_s;
  logic             fifo_push_ok_s;
  logic             fifo_pop_s;
  logic [IDX_W-1:0] fifo_head_s;
  logic [CNT_W-1:0] fifo_count_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;

  // Output slice state
  logic             slice_valid_r;
  logic [IDX_W-1:0] slice_dest_r;
  logic             dest_ready_s;
  logic             s_rready_s;
  logic             accept_s;

  logic [REQ_NUM*DATA_WIDTH-1:0] m_rdata_r;
  logic [REQ_NUM*2-1:0]          m_rresp_r;
  logic [REQ_NUM-1:0]            m_rlast_r;
  logic [REQ_NUM-1:0]            m_rvalid_r;
  logic                          push_err_r;

  // Index range check; one extra bit so REQ_NUM == 2**IDX_W compares correctly.
  always_comb begin
    idx_ok_s    = ({1'b0, ar_index} < (IDX_W + 1)'(REQ_NUM));
    fifo_push_s = ar_fire & idx_ok_s;
  end

  axi_ic_order_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (DEPTH)
  ) u_order_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push_s),
    .push_data (ar_index),
    .pop       (fifo_pop_s),
    .head      (fifo_head_s),
    .count     (fifo_count_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .push_ok   (fifo_push_ok_s)
  );

  // Ready of the master currently owning the slice, plus slave handshake.
  always_comb begin
    dest_ready_s = 1'b0;
    for (int i = 0; i < REQ_NUM; i++) begin
      dest_ready_s = dest_ready_s | (m_rready[i] & (slice_dest_r == IDX_W'(i)));
    end
    // Without a FIFO entry there is no known destination, so the beat stalls.
    s_rready_s = ~fifo_empty_s & (~slice_valid_r | dest_ready_s);
    accept_s   = s_rvalid & s_rready_s;
    // The last beat retires the head immediately, so the next beat (even the
    // very next cycle) already sees the following burst's destination.
    fifo_pop_s = accept_s & s_rlast;
  end

  // Output slice: load on accept, drain when the owning master takes the beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slice_valid_r <= 1'b0;
      slice_dest_r  <= {IDX_W{1'b0}};
      m_rvalid_r    <= {REQ_NUM{1'b0}};
      m_rdata_r     <= {(REQ_NUM*DATA_WIDTH){1'b0}};
      m_rresp_r     <= {REQ_NUM{AXI_RESP_OKAY}};
      m_rlast_r     <= {REQ_NUM{1'b0}};
    end else if (accept_s) begin
      slice_valid_r <= 1'b1;
      slice_dest_r  <= fifo_head_s;
      // Only the destination lane carries the beat; every other lane is zero.
      for (int i = 0; i < REQ_NUM; i++) begin
        if (fifo_head_s == IDX_W'(i)) begin
          m_rvalid_r[i]                          <= 1'b1;
          m_rdata_r[i*DATA_WIDTH +: DATA_WIDTH]  <= s_rdata;
          m_rresp_r[i*2 +: 2]                    <= s_rresp;
          m_rlast_r[i]                           <= s_rlast;
        end else begin
          m_rvalid_r[i]                          <= 1'b0;
          m_rdata_r[i*DATA_WIDTH +: DATA_WIDTH]  <= {DATA_WIDTH{1'b0}};
          m_rresp_r[i*2 +: 2]                    <= AXI_RESP_OKAY;
          m_rlast_r[i]                           <= 1'b0;
        end
      end
    end else if (slice_valid_r && dest_ready_s) begin
      slice_valid_r <= 1'b0;
      m_rvalid_r    <= {REQ_NUM{1'b0}};
      m_rdata_r     <= {(REQ_NUM*DATA_WIDTH){1'b0}};
      m_rresp_r     <= {REQ_NUM{AXI_RESP_OKAY}};
      m_rlast_r     <= {REQ_NUM{1'b0}};
    end
  end

  // Sticky error: any AR that could not be recorded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      push_err_r <= 1'b0;
    end else if (ar_fire && !fifo_push_ok_s) begin
      push_err_r <= 1'b1;
    end
  end

  assign s_rready    = s_rready_s;
  assign m_rvalid    = m_rvalid_r;
  assign m_rdata     = m_rdata_r;
  assign m_rresp     = m_rresp_r;
  assign m_rlast     = m_rlast_r;
  assign order_full  = fifo_full_s;
  assign outstanding = fifo_count_s;
  assign push_err    = push_err_r;

endmodule

// File: tb/tb_axi_rd_resp_router.sv
// ---------------------------------------------------------------------------
// tb_axi_rd_resp_router
//   Self-checking bench: a queue-based reference model of the router is
//   advanced on every rising edge and compared against the DUT on every
//   falling edge; directed scenarios add literal expectations.
// ---------------------------------------------------------------------------
module tb_axi_rd_resp_router;

  localparam int REQ_NUM = 3;
  localparam int DW      = 128;
  localparam int DEPTH   = 4;
  localparam int IDX_W   = 2;
  localparam int CNT_W   = 3;
  localparam int VW      = REQ_NUM * DW;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 ar_fire;
  logic [IDX_W-1:0]     ar_index;
  logic                 order_full;
  logic [CNT_W-1:0]     outstanding;
  logic                 push_err;
  logic [DW-1:0]        s_rdata;
  logic [1:0]           s_rresp;
  logic                 s_rlast;
  logic                 s_rvalid;
  logic                 s_rready;
  logic [VW-1:0]        m_rdata;
  logic [REQ_NUM*2-1:0] m_rresp;
  logic [REQ_NUM-1:0]   m_rlast;
  logic [REQ_NUM-1:0]   m_rvalid;
  logic [REQ_NUM-1:0]   m_rready;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  axi_rd_resp_router #(.REQ_NUM(REQ_NUM), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ar_fire(ar_fire), .ar_index(ar_index),
    .order_full(order_full), .outstanding(outstanding), .push_err(push_err),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid),
    .s_rready(s_rready), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  function automatic void chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  int            q[$];
  bit            sv;
  int            sd;
  logic [DW-1:0] sdata;
  logic [1:0]    sresp;
  bit            slast;
  bit            err;
  int            cyc = 0;

  typedef struct { int m; logic [DW-1:0] d; logic l; int c; } dlv_t;
  dlv_t dlog[$];

  bit            m_rdy, m_acc, m_pop, m_push;
  logic [VW-1:0] e_d;
  logic [REQ_NUM*2-1:0] e_r;
  logic [REQ_NUM-1:0]   e_l, e_v;
  dlv_t          ent;

  function automatic void model_clear();
    q.delete();
    sv  = 1'b0;
    err = 1'b0;
  endfunction

  initial begin
    model_clear();
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        model_clear();
      end else begin
        m_rdy  = (q.size() > 0) && (!sv || m_rready[sd]);
        m_acc  = s_rvalid && m_rdy;
        m_pop  = m_acc && s_rlast;
        m_push = ar_fire && (int'(ar_index) < REQ_NUM) && (q.size() < DEPTH || m_pop);
        if (ar_fire && !m_push) err = 1'b1;
        if (m_acc) begin
          sv = 1'b1; sd = q[0]; sdata = s_rdata; sresp = s_rresp; slast = s_rlast;
        end else if (sv && m_rready[sd]) begin
          sv = 1'b0;
        end
        if (m_pop) void'(q.pop_front());
        if (m_push) q.push_back(int'(ar_index));
      end
      @(negedge clk);
      if (rst) model_clear();
      m_rdy = (q.size() > 0) && (!sv || m_rready[sd]);
      chk("s_rready", VW'(s_rready), VW'(m_rdy));
      chk("outstanding", VW'(outstanding), VW'(q.size()));
      chk("order_full", VW'(order_full), VW'(q.size() == DEPTH));
      chk("push_err", VW'(push_err), VW'(err));
      e_v = '0; e_d = '0; e_r = '0; e_l = '0;
      if (sv) begin
        e_v[sd] = 1'b1; e_d[sd*DW +: DW] = sdata; e_r[sd*2 +: 2] = sresp; e_l[sd] = slast;
      end
      chk("m_rvalid", VW'(m_rvalid), VW'(e_v));
      if (sv || rst) begin
        chk("m_rdata", m_rdata, e_d);
        chk("m_rresp", VW'(m_rresp), VW'(e_r));
        chk("m_rlast", VW'(m_rlast), VW'(e_l));
      end
      for (int i = 0; i < REQ_NUM; i++) begin
        if (m_rvalid[i] && m_rready[i]) begin
          ent.m = i; ent.d = m_rdata[i*DW +: DW]; ent.l = m_rlast[i]; ent.c = cyc;
          dlog.push_back(ent);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic push_idx(input int idx);
    ar_fire  = 1'b1;
    ar_index = IDX_W'(idx);
    step();
    ar_fire  = 1'b0;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic last);
    int t;
    t = 0;
    s_rvalid = 1'b1; s_rdata = d; s_rlast = last; s_rresp = d[1:0];
    forever begin
      @(negedge clk);
      if (s_rready) break;
      t++;
      if (t > 50) begin
        n_cmp++; n_bad++;
        $display("FAIL send_timeout: s_rready stuck at 0, required 1");
        break;
      end
    end
    step();
    s_rvalid = 1'b0; s_rlast = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  logic [DW-1:0] tmp_d;
  int            exp_m[7] = '{2, 2, 2, 2, 0, 1, 1};
  logic          exp_l[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    rst = 1'b1; ar_fire = 1'b0; ar_index = '0; s_rdata = '0; s_rresp = 2'b00;
    s_rlast = 1'b0; s_rvalid = 1'b0; m_rready = '0;
    step(); step();
    @(negedge clk);
    chk("reset_m_rvalid", VW'(m_rvalid), VW'(0));
    chk("reset_outstanding", VW'(outstanding), VW'(0));
    step();
    rst = 1'b0;

    // Invalid index, then reset with two bursts outstanding and a full slice.
    push_idx(3);
    @(negedge clk);
    chk("badidx_push_err", VW'(push_err), VW'(1));
    chk("badidx_outstanding", VW'(outstanding), VW'(0));
    step();
    push_idx(0); push_idx(1);
    send_beat(128'h77, 1'b0);
    @(negedge clk);
    chk("mid_m_rvalid", VW'(m_rvalid), VW'(3'b001));
    chk("mid_outstanding", VW'(outstanding), VW'(2));
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_m_rvalid", VW'(m_rvalid), VW'(0));
    chk("rst_m_rdata", m_rdata, VW'(0));
    chk("rst_outstanding", VW'(outstanding), VW'(0));
    chk("rst_push_err", VW'(push_err), VW'(0));
    step();
    rst = 1'b0;

    // Ordered routing: 4, 1 and 2 beat bursts to masters 2, 0, 1.
    m_rready = 3'b111;
    push_idx(2); push_idx(0); push_idx(1);
    dlog.delete();
    for (int k = 0; k < 7; k++) begin
      tmp_d = DW'(16 + k);
      send_beat(tmp_d, exp_l[k]);
    end
    step(); step();
    @(negedge clk);
    chk("order_count", VW'(dlog.size()), VW'(7));
    for (int k = 0; k < 7 && k < dlog.size(); k++) begin
      chk("order_master", VW'(dlog[k].m), VW'(exp_m[k]));
      chk("order_data", VW'(dlog[k].d), VW'(16 + k));
      chk("order_last", VW'(dlog[k].l), VW'(exp_l[k]));
      chk("order_gap", VW'(dlog[k].c - dlog[0].c), VW'(k));
    end
    chk("order_outstanding", VW'(outstanding), VW'(0));
    step();

    // Backpressure on master 1 mid-burst.
    push_idx(1);
    dlog.delete();
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          tmp_d = DW'(64 + k);
          send_beat(tmp_d, (k == 7));
        end
      end
      begin
        step(); step(); step();
        m_rready[1] = 1'b0;
        repeat (5) step();
        m_rready[1] = 1'b1;
      end
    join
    step(); step();
    @(negedge clk);
    chk("bp_count", VW'(dlog.size()), VW'(8));
    for (int k = 0; k < 8 && k < dlog.size(); k++) begin
      chk("bp_master", VW'(dlog[k].m), VW'(1));
      chk("bp_data", VW'(dlog[k].d), VW'(64 + k));
      chk("bp_last", VW'(dlog[k].l), VW'(k == 7));
    end
    step();

    // Full / overflow.
    reset_dut();
    push_idx(0); push_idx(1); push_idx(2); push_idx(0);
    @(negedge clk);
    chk("full_flag", VW'(order_full), VW'(1));
    chk("full_outstanding", VW'(outstanding), VW'(4));
    step();
    push_idx(1);
    @(negedge clk);
    chk("ovf_push_err", VW'(push_err), VW'(1));
    chk("ovf_outstanding", VW'(outstanding), VW'(4));
    step();
    reset_dut();
    push_idx(0); push_idx(1); push_idx(2); push_idx(0);
    ar_fire = 1'b1; ar_index = 2'd2;
    s_rvalid = 1'b1; s_rlast = 1'b1; s_rdata = 128'h5A;
    step();
    ar_fire = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0;
    @(negedge clk);
    chk("popush_err", VW'(push_err), VW'(0));
    chk("popush_outstanding", VW'(outstanding), VW'(4));
    step();

    // Empty stall.
    reset_dut();
    s_rvalid = 1'b1; s_rdata = 128'h99; s_rlast = 1'b1; s_rresp = 2'b01;
    for (int k = 0; k < 3; k++) begin
      step();
      @(negedge clk);
      chk("stall_s_rready", VW'(s_rready), VW'(0));
      chk("stall_m_rvalid", VW'(m_rvalid), VW'(0));
    end
    step();
    push_idx(1);
    @(negedge clk);
    chk("unstall_s_rready", VW'(s_rready), VW'(1));
    step();
    s_rvalid = 1'b0; s_rlast = 1'b0;
    @(negedge clk);
    chk("unstall_m_rvalid", VW'(m_rvalid), VW'(3'b010));
    chk("unstall_data", VW'(m_rdata[DW +: DW]), VW'(128'h99));
    step();

    // Randomized traffic with periodic resets.
    for (int n = 0; n < 3000; n++) begin
      int r;
      if (n % 600 == 0) begin
        rst = 1'b1;
      end else begin
        rst = 1'b0;
      end
      ar_fire  = ($urandom_range(0, 2) == 0);
      r        = $urandom_range(0, 15);
      ar_index = (r == 15) ? 2'd3 : IDX_W'(r % 3);
      s_rvalid = ($urandom_range(0, 9) < 7);
      s_rdata  = {$urandom, $urandom, $urandom, $urandom};
      s_rresp  = 2'($urandom_range(0, 3));
      s_rlast  = ($urandom_range(0, 2) == 0);
      m_rready = 3'($urandom_range(0, 7)) | 3'($urandom_range(0, 7));
      step();
    end
    rst = 1'b0; ar_fire = 1'b0; s_rvalid = 1'b0;
    step(); step();
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
